instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 50 +++++
 rtl/instr_fetch.sv | 130 +++++++++++++
 tb/tb_instr_fetch.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: instruction field positions,
// field extraction helpers and the IF/ID payload type.
package instr_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } if_id_t;

  function automatic logic [5:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [5:0] funct_of(input logic [XLEN-1:0] instr);
    return instr[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer that catches a
// response arriving while decode is stalled.
module if_id_reg
  import instr_fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush_i,
  input  logic   stall_i,
  input  logic   fill_i,
  input  logic   fill_from_skid_i,
  input  logic   skid_we_i,
  input  if_id_t resp_i,
  output logic   id_valid_o,
  output if_id_t id_o
);

  if_id_t skid_q;
  if_id_t id_q;
  logic   valid_q;

  // NOTE: the skid entry is a plain register, so it is reset like any other
  // flop; this keeps its contents deterministic in simulation and silicon.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (skid_we_i) begin
      skid_q <= resp_i;
    end
  end

  // Flush wins over everything; without a fill, an unstalled decode drains to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      id_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      id_q    <= fill_from_skid_i ? skid_q : resp_i;
    end else if (!stall_i) begin
      valid_q <= 1'b0;
    end
  end

  assign id_valid_o = valid_q;
  assign id_o       = id_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register and request FSM with one outstanding
// memory request, feeding the IF/ID register.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MIN_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct
);

  if (MIN_LAT < 1) begin : g_min_lat_check
    $error("instr_fetch: MIN_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_BUF   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        fill, fill_from_skid, skid_we;
  if_id_t      resp, id_entry;

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ISSUE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and infers a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    drop_d         = drop_q;
    fill           = 1'b0;
    fill_from_skid = 1'b0;
    skid_we        = 1'b0;
    case (state_q)
      S_ISSUE: begin
        state_d = S_WAIT;
        if (redirect) begin
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_ISSUE;
          drop_d  = 1'b0;
          if (!drop_q && !redirect) begin
            if (stall) begin
              skid_we = 1'b1;
              state_d = S_BUF;
            end else begin
              fill = 1'b1;
            end
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
        if (redirect) pc_d = redirect_pc;
      end
      S_BUF: begin
        if (redirect) begin
          state_d = S_ISSUE;
          pc_d    = redirect_pc;
        end else if (!stall) begin
          fill           = 1'b1;
          fill_from_skid = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase
  end

  // Gated by rst_n so no request leaks out while the stage is held in reset.
  assign imem_req  = (state_q == S_ISSUE) && rst_n;
  assign imem_addr = pc_q;

  // In WAIT the PC has already advanced, so it equals the fetched PC plus 4.
  assign resp = '{instr: imem_rdata, pc4: pc_q};

  if_id_reg u_if_id_reg (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (redirect),
    .stall_i          (stall),
    .fill_i           (fill),
    .fill_from_skid_i (fill_from_skid),
    .skid_we_i        (skid_we),
    .resp_i           (resp),
    .id_valid_o       (id_valid),
    .id_o             (id_entry)
  );

  assign id_instr  = id_entry.instr;
  assign id_pc4    = id_entry.pc4;
  assign id_opcode = opcode_of(id_entry.instr);
  assign id_funct  = funct_of(id_entry.instr);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-programmable memory responder plus
// per-scenario tasks with hand-derived cycle-by-cycle expectations.
module tb_instr_fetch;

  localparam logic [31:0] SPECIAL_ADDR = 32'h0000_0004;
  localparam logic [31:0] SPECIAL_DATA = 32'h2008_0005;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model state; the bench can also inject a stray response directly.
  int          mem_lat = 1;
  logic        mem_clr = 1'b1;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_addr_q = 32'h0;
  int          m_cnt = 0;
  logic        t_rvalid = 1'b0;
  logic [31:0] t_rdata = 32'h0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .MIN_LAT(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc4      (id_pc4),
    .id_opcode   (id_opcode),
    .id_funct    (id_funct)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == SPECIAL_ADDR) ? SPECIAL_DATA : {8'hC0, a[23:0]};
  endfunction

  assign imem_rvalid = m_rvalid | t_rvalid;
  assign imem_rdata  = t_rvalid ? t_rdata : m_rdata;

  always @(posedge clk) begin
    m_rvalid <= 1'b0;
    if (mem_clr) begin
      m_cnt <= 0;
    end else begin
      if (m_cnt == 1) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem_word(m_addr_q);
      end
      if (m_cnt > 0) m_cnt <= m_cnt - 1;
      if (imem_req) begin
        if (mem_lat == 1) begin
          m_rvalid <= 1'b1;
          m_rdata  <= mem_word(imem_addr);
        end else begin
          m_addr_q <= imem_addr;
          m_cnt    <= mem_lat - 1;
        end
      end
    end
  end

  // Leaves the bench in cycle 0 after reset release, 1 ns past the falling edge.
  task automatic do_reset(input int lat);
    @(negedge clk);
    rst_n = 1'b0; mem_clr = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; t_rvalid = 1'b0; mem_lat = lat;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_clr = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", imem_req); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", id_valid); end
    n_cmp++; if (id_instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr got %h want 0", id_instr); end
    n_cmp++; if (id_pc4 !== 32'h0) begin n_bad++; $display("FAIL rst_pc4 got %h want 0", id_pc4); end
    rst_n = 1'b1; mem_clr = 1'b0; mem_lat = 1;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rst_first_req got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_first_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_basic_stream();
    logic        e_req, e_val;
    logic [31:0] e_pc4;
    do_reset(1);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      e_req = (k % 2 == 0);
      e_val = (k >= 2) && (k % 2 == 0);
      e_pc4 = 32'(2 * k);
      n_cmp++; if (imem_req !== e_req) begin n_bad++; $display("FAIL basic_req k=%0d got %b want %b", k, imem_req, e_req); end
      if (e_req) begin
        n_cmp++; if (imem_addr !== 32'(2 * k)) begin n_bad++; $display("FAIL basic_addr k=%0d got %h want %h", k, imem_addr, 2 * k); end
      end
      n_cmp++; if (id_valid !== e_val) begin n_bad++; $display("FAIL basic_valid k=%0d got %b want %b", k, id_valid, e_val); end
      if (e_val) begin
        n_cmp++; if (id_pc4 !== e_pc4) begin n_bad++; $display("FAIL basic_pc4 k=%0d got %h want %h", k, id_pc4, e_pc4); end
        n_cmp++; if (id_instr !== mem_word(e_pc4 - 32'd4)) begin n_bad++; $display("FAIL basic_instr k=%0d got %h want %h", k, id_instr, mem_word(e_pc4 - 32'd4)); end
      end
    end
  endtask

  task automatic test_stall_skid();
    do_reset(1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      stall = (k >= 2) && (k <= 5);
      #1;
      if (k >= 2 && k <= 6) begin
        n_cmp++; if (imem_req !== (k == 2)) begin n_bad++; $display("FAIL stall_req k=%0d got %b", k, imem_req); end
        n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid k=%0d got %b want 1", k, id_valid); end
        n_cmp++; if (id_instr !== 32'hC000_0000) begin n_bad++; $display("FAIL stall_hold_instr k=%0d got %h want c0000000", k, id_instr); end
        n_cmp++; if (id_pc4 !== 32'h4) begin n_bad++; $display("FAIL stall_hold_pc4 k=%0d got %h want 4", k, id_pc4); end
      end
    end
    n_cmp++; if (id_instr !== 32'h2008_0005) begin n_bad++; $display("FAIL stall_release_instr got %h want 20080005", id_instr); end
    n_cmp++; if (id_opcode !== 6'h08) begin n_bad++; $display("FAIL stall_opcode got %h want 08", id_opcode); end
    n_cmp++; if (id_funct !== 6'h05) begin n_bad++; $display("FAIL stall_funct got %h want 05", id_funct); end
    n_cmp++; if (id_pc4 !== 32'h8) begin n_bad++; $display("FAIL stall_release_pc4 got %h want 8", id_pc4); end
    n_cmp++; if (!(imem_req === 1'b1 && imem_addr === 32'h8)) begin n_bad++; $display("FAIL stall_next_req got %b/%h want 1/8", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    do_reset(3);
    for (int k = 1; k < 17; k++) begin
      @(negedge clk);
      redirect = (k == 9); redirect_pc = 32'h0000_0100;
      #1;
      if (k == 8) begin
        n_cmp++; if (!(id_valid === 1'b1 && id_pc4 === 32'h8)) begin n_bad++; $display("FAIL rdw_pre got %b/%h want 1/8", id_valid, id_pc4); end
        n_cmp++; if (!(imem_req === 1'b1 && imem_addr === 32'h8)) begin n_bad++; $display("FAIL rdw_req8 got %b/%h want 1/8", imem_req, imem_addr); end
      end
      if (k >= 9 && k <= 15) begin
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rdw_valid k=%0d got %b want 0", k, id_valid); end
      end
      if (k >= 9 && k <= 11) begin
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rdw_noreq k=%0d got %b want 0", k, imem_req); end
      end
      if (k == 12) begin
        n_cmp++; if (!(imem_req === 1'b1 && imem_addr === 32'h100)) begin n_bad++; $display("FAIL rdw_target got %b/%h want 1/100", imem_req, imem_addr); end
      end
    end
    n_cmp++; if (!(id_valid === 1'b1 && id_instr === 32'hC000_0100 && id_pc4 === 32'h104)) begin
      n_bad++; $display("FAIL rdw_load got %b/%h/%h want 1/c0000100/104", id_valid, id_instr, id_pc4);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset(1);
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      stall = (k == 2) || (k == 3);
      redirect = (k == 3); redirect_pc = 32'h0000_0040;
      #1;
      if (k == 3) begin
        n_cmp++; if (!(id_valid === 1'b1 && id_pc4 === 32'h4)) begin n_bad++; $display("FAIL rrv_hold got %b/%h want 1/4", id_valid, id_pc4); end
      end
      if (k == 4) begin
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rrv_cleared got %b want 0", id_valid); end
        n_cmp++; if (!(imem_req === 1'b1 && imem_addr === 32'h40)) begin n_bad++; $display("FAIL rrv_target got %b/%h want 1/40", imem_req, imem_addr); end
      end
    end
    n_cmp++; if (!(id_valid === 1'b1 && id_instr === 32'hC000_0040 && id_pc4 === 32'h44)) begin
      n_bad++; $display("FAIL rrv_load got %b/%h/%h want 1/c0000040/44", id_valid, id_instr, id_pc4);
    end
  endtask

  task automatic test_redirect_buf();
    do_reset(1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      stall = (k >= 2) && (k <= 4);
      redirect = (k == 4); redirect_pc = 32'h0000_0200;
      #1;
      if (k == 4) begin
        n_cmp++; if (!(id_valid === 1'b1 && imem_req === 1'b0)) begin n_bad++; $display("FAIL rbuf_in_buf got %b/%b want 1/0", id_valid, imem_req); end
      end
      if (k == 5) begin
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rbuf_cleared got %b want 0", id_valid); end
        n_cmp++; if (!(imem_req === 1'b1 && imem_addr === 32'h200)) begin n_bad++; $display("FAIL rbuf_target got %b/%h want 1/200", imem_req, imem_addr); end
      end
    end
    n_cmp++; if (!(id_valid === 1'b1 && id_instr === 32'hC000_0200 && id_pc4 === 32'h204)) begin
      n_bad++; $display("FAIL rbuf_load got %b/%h/%h want 1/c0000200/204", id_valid, id_instr, id_pc4);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset(1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    n_cmp++; if (!(imem_req === 1'b1 && imem_addr === 32'h0)) begin n_bad++; $display("FAIL wrap_first got %b/%h want 1/0", imem_req, imem_addr); end
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      redirect = 1'b0;
      #1;
      if (k == 2) begin
        n_cmp++; if (!(imem_req === 1'b1 && imem_addr === 32'hFFFF_FFFC)) begin n_bad++; $display("FAIL wrap_top got %b/%h want 1/fffffffc", imem_req, imem_addr); end
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_dropped got %b want 0", id_valid); end
      end
    end
    n_cmp++; if (!(imem_req === 1'b1 && imem_addr === 32'h0)) begin n_bad++; $display("FAIL wrap_addr got %b/%h want 1/0", imem_req, imem_addr); end
    n_cmp++; if (!(id_valid === 1'b1 && id_pc4 === 32'h0 && id_instr === 32'hC0FF_FFFC)) begin
      n_bad++; $display("FAIL wrap_pc4 got %b/%h/%h want 1/0/c0fffffc", id_valid, id_pc4, id_instr);
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset(3);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) begin rst_n = 1'b0; mem_clr = 1'b1; end
      if (k == 3) begin rst_n = 1'b1; mem_clr = 1'b0; t_rvalid = 1'b1; t_rdata = 32'hDEAD_BEEF; end
      if (k == 4) t_rvalid = 1'b0;
      #1;
      if (k <= 2) begin
        n_cmp++; if (!(imem_req === 1'b0 && id_valid === 1'b0)) begin n_bad++; $display("FAIL mid_rst k=%0d got %b/%b want 0/0", k, imem_req, id_valid); end
      end
      if (k == 3) begin
        n_cmp++; if (!(imem_req === 1'b1 && imem_addr === 32'h0)) begin n_bad++; $display("FAIL mid_first got %b/%h want 1/0", imem_req, imem_addr); end
      end
      if (k >= 4 && k <= 6) begin
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL mid_late_ignored k=%0d got %b want 0", k, id_valid); end
      end
    end
    n_cmp++; if (!(id_valid === 1'b1 && id_instr === 32'hC000_0000 && id_pc4 === 32'h4)) begin
      n_bad++; $display("FAIL mid_load got %b/%h/%h want 1/c0000000/4", id_valid, id_instr, id_pc4);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_rvalid();
    test_redirect_buf();
    test_pc_wrap();
    test_reset_midfetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
